// File: rtl/word_serializer_pkg.sv
// Shared constants and width helpers for the word serializer.
// The FSM state type lives here so checkers can bind to it by name.
package word_serializer_pkg;

  localparam int WORD_W = 32;
  localparam int BYTE_W = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  function automatic int calc_n(input int in_w, input int out_w);
    return in_w / out_w;
  endfunction

  // Index/count width; never zero so single-chunk builds still get a 1-bit port.
  function automatic int calc_cw(input int in_w, input int out_w);
    int c;
    c = clog2(in_w / out_w);
    return (c < 1) ? 1 : c;
  endfunction

endpackage

// File: rtl/word_serializer_chunk_select.sv
// Picks the chunk at the emitting end of the shift register.
module word_serializer_chunk_select #(
  parameter int IN_W      = 32,
  parameter int OUT_W     = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic [IN_W-1:0]  shift_i,
  output logic [OUT_W-1:0] chunk_o
);

  generate
    if (MSB_FIRST != 0) begin : g_msb
      assign chunk_o = shift_i[IN_W-1 -: OUT_W];
    end else begin : g_lsb
      assign chunk_o = shift_i[OUT_W-1:0];
    end
  endgenerate

endmodule

// File: rtl/word_serializer.sv
// Splits one IN_W word per input handshake into OUT_W chunks, one per output beat,
// with configurable chunk order and a per-word chunk count.
module word_serializer
  import word_serializer_pkg::*;
#(
  parameter int IN_W      = WORD_W,
  parameter int OUT_W     = BYTE_W,
  parameter int MSB_FIRST = 1,
  localparam int N        = calc_n(IN_W, OUT_W),
  localparam int CW       = calc_cw(IN_W, OUT_W)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IN_W-1:0]  in_data,
  input  logic [CW-1:0]    in_cnt,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [CW-1:0]    out_idx,
  output logic             out_last,
  output logic             out_valid,
  input  logic             out_ready
);

  state_e          state_q, state_d;
  logic [IN_W-1:0] shift_q, shift_d;
  logic [CW-1:0]   rem_q, rem_d;
  logic [CW-1:0]   idx_q, idx_d;
  logic [CW-1:0]   cnt_sat;
  logic            in_acc;
  logic            out_acc;

  // Valid/ready: a transfer happens on a rising edge where valid && ready; valid never
  // waits for ready, and the presented beat is held unchanged until it transfers.
  // in_ready depends on out_ready (drain of the last chunk) but never on in_valid.
  assign out_valid = (state_q == ST_SEND);
  assign out_last  = out_valid && (rem_q == '0);
  assign out_idx   = idx_q;
  assign out_acc   = out_valid && out_ready;
  assign in_ready  = (state_q == ST_IDLE) || (out_acc && out_last);
  assign in_acc    = in_valid && in_ready;

  // Counts above N-1 are only representable when N is not a power of two.
  generate
    if ((1 << CW) > N) begin : g_sat
      assign cnt_sat = (in_cnt > CW'(N - 1)) ? CW'(N - 1) : in_cnt;
    end else begin : g_nosat
      assign cnt_sat = in_cnt;
    end
  endgenerate

  word_serializer_chunk_select #(
    .IN_W      (IN_W),
    .OUT_W     (OUT_W),
    .MSB_FIRST (MSB_FIRST)
  ) u_chunk_select (
    .shift_i (shift_q),
    .chunk_o (out_data)
  );

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    rem_d   = rem_q;
    idx_d   = idx_q;
    if (in_acc) begin
      // Also covers the last-chunk-plus-new-word case, giving zero-bubble words.
      shift_d = in_data;
      rem_d   = cnt_sat;
      idx_d   = '0;
      state_d = ST_SEND;
    end else if (out_acc) begin
      if (out_last) begin
        state_d = ST_IDLE;
      end else begin
        shift_d = (MSB_FIRST != 0) ? (shift_q << OUT_W) : (shift_q >> OUT_W);
        rem_d   = rem_q - CW'(1);
        idx_d   = idx_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      rem_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      rem_q   <= rem_d;
      idx_q   <= idx_d;
    end
  end

endmodule

// File: tb/tb_word_serializer.sv
// Bench for word_serializer: three builds (32/8 MSB-first, 32/8 LSB-first, 24/8 MSB-first)
// share one stimulus stream and are checked every cycle against a chunk-queue model.
module tb_word_serializer;

  logic        clk;
  logic        reset;
  logic [31:0] in_data;
  logic [1:0]  in_cnt;
  logic        in_valid;
  logic        out_ready;

  logic       in_ready_0, out_last_0, out_valid_0;
  logic [7:0] out_data_0;
  logic [1:0] out_idx_0;
  logic       in_ready_1, out_last_1, out_valid_1;
  logic [7:0] out_data_1;
  logic [1:0] out_idx_1;
  logic       in_ready_2, out_last_2, out_valid_2;
  logic [7:0] out_data_2;
  logic [1:0] out_idx_2;

  // Expected beats, packed as {last, idx[1:0], data[7:0]}.
  logic [10:0] exp_q0[$];
  logic [10:0] exp_q1[$];
  logic [10:0] exp_q2[$];
  logic [7:0]  log0[$];
  logic [7:0]  log1[$];
  logic [7:0]  log2[$];
  logic [7:0]  rdy_log0[$];
  bit          zero_ok;
  int          n_checks;
  int          n_fail;

  word_serializer #(.IN_W(32), .OUT_W(8), .MSB_FIRST(1)) u_msb (
    .clk(clk), .reset(reset), .in_data(in_data), .in_cnt(in_cnt),
    .in_valid(in_valid), .in_ready(in_ready_0), .out_data(out_data_0),
    .out_idx(out_idx_0), .out_last(out_last_0), .out_valid(out_valid_0),
    .out_ready(out_ready)
  );

  word_serializer #(.IN_W(32), .OUT_W(8), .MSB_FIRST(0)) u_lsb (
    .clk(clk), .reset(reset), .in_data(in_data), .in_cnt(in_cnt),
    .in_valid(in_valid), .in_ready(in_ready_1), .out_data(out_data_1),
    .out_idx(out_idx_1), .out_last(out_last_1), .out_valid(out_valid_1),
    .out_ready(out_ready)
  );

  word_serializer #(.IN_W(24), .OUT_W(8), .MSB_FIRST(1)) u_n3 (
    .clk(clk), .reset(reset), .in_data(in_data[23:0]), .in_cnt(in_cnt),
    .in_valid(in_valid), .in_ready(in_ready_2), .out_data(out_data_2),
    .out_idx(out_idx_2), .out_last(out_last_2), .out_valid(out_valid_2),
    .out_ready(out_ready)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit exp_rdy(input int sz);
    return (sz == 0) || (sz == 1 && out_ready);
  endfunction

  // Chunk k of word w for an n-chunk build, counting from the emitting end.
  function automatic logic [10:0] chunk_entry(input int n, input int msb, input logic [31:0] w,
                                              input int last_k, input int k);
    int         pos;
    logic [7:0] b;
    pos = (msb != 0) ? (n - 1 - k) : k;
    b   = 8'((w >> (8 * pos)) & 32'hFF);
    return {k == last_k, 2'(k), b};
  endfunction

  // ---------------- model ----------------
  always @(posedge clk or posedge reset) begin : model
    bit r0, r1, r2;
    int c4, c3;
    if (reset) begin
      exp_q0.delete();
      exp_q1.delete();
      exp_q2.delete();
      zero_ok = 1'b1;
    end else begin
      r0 = exp_rdy(exp_q0.size());
      r1 = exp_rdy(exp_q1.size());
      r2 = exp_rdy(exp_q2.size());
      if (exp_q0.size() != 0 && out_ready) void'(exp_q0.pop_front());
      if (exp_q1.size() != 0 && out_ready) void'(exp_q1.pop_front());
      if (exp_q2.size() != 0 && out_ready) void'(exp_q2.pop_front());
      c4 = int'(in_cnt);
      c3 = (int'(in_cnt) > 2) ? 2 : int'(in_cnt);
      if (in_valid && r0)
        for (int k = 0; k <= c4; k++) exp_q0.push_back(chunk_entry(4, 1, in_data, c4, k));
      if (in_valid && r1)
        for (int k = 0; k <= c4; k++) exp_q1.push_back(chunk_entry(4, 0, in_data, c4, k));
      if (in_valid && r2)
        for (int k = 0; k <= c3; k++)
          exp_q2.push_back(chunk_entry(3, 1, {8'h00, in_data[23:0]}, c3, k));
      if (in_valid && (r0 || r1 || r2)) zero_ok = 1'b0;
    end
  end

  // ---------------- compare + beat logging ----------------
  task automatic cmp(input string tag, input logic rdy, input logic vld, input logic [7:0] d,
                     input logic [1:0] i, input logic lst, input int sz, input logic [10:0] front);
    check({tag, "_out_valid"}, vld, sz != 0);
    check({tag, "_in_ready"}, rdy, exp_rdy(sz));
    if (sz != 0) begin
      check({tag, "_out_data"}, d, front[7:0]);
      check({tag, "_out_idx"}, i, front[9:8]);
      check({tag, "_out_last"}, lst, front[10]);
    end
  endtask

  always @(negedge clk) begin
    cmp("msb", in_ready_0, out_valid_0, out_data_0, out_idx_0, out_last_0,
        exp_q0.size(), (exp_q0.size() != 0) ? exp_q0[0] : 11'h0);
    cmp("lsb", in_ready_1, out_valid_1, out_data_1, out_idx_1, out_last_1,
        exp_q1.size(), (exp_q1.size() != 0) ? exp_q1[0] : 11'h0);
    cmp("n3", in_ready_2, out_valid_2, out_data_2, out_idx_2, out_last_2,
        exp_q2.size(), (exp_q2.size() != 0) ? exp_q2[0] : 11'h0);
    if (zero_ok) begin
      check("msb_cleared_data", out_data_0, 8'h00);
      check("lsb_cleared_data", out_data_1, 8'h00);
      check("n3_cleared_data", out_data_2, 8'h00);
    end
    if (out_valid_0 && out_ready) log0.push_back(out_data_0);
    if (out_valid_1 && out_ready) log1.push_back(out_data_1);
    if (out_valid_2 && out_ready) log2.push_back(out_data_2);
    if (out_valid_0 && in_ready_0) rdy_log0.push_back(out_data_0);
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    log0.delete();
    log1.delete();
    log2.delete();
    rdy_log0.delete();
  endtask

  // Holds in_valid with word w until the 32-bit MSB-first build takes it.
  task automatic present(input logic [31:0] w, input logic [1:0] c);
    int t;
    in_data  = w;
    in_cnt   = c;
    in_valid = 1'b1;
    t = 0;
    while (!exp_rdy(exp_q0.size()) && t < 100) begin
      tick();
      t++;
    end
    if (t >= 100) check("present_timeout", 1, 0);
    tick();
  endtask

  task automatic send(input logic [31:0] w, input logic [1:0] c);
    present(w, c);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((exp_q0.size() != 0 || exp_q1.size() != 0 || exp_q2.size() != 0) && t < 100) begin
      tick();
      t++;
    end
    if (t >= 100) check("drain_timeout", 1, 0);
    tick();
  endtask

  // Compares a beat log against n bytes packed first-beat-most-significant in exp.
  task automatic check_seq(input string name, input int k, input logic [63:0] exp, input int n);
    logic [7:0] tmp[$];
    case (k)
      0:       tmp = log0;
      1:       tmp = log1;
      2:       tmp = log2;
      default: tmp = rdy_log0;
    endcase
    check({name, "_len"}, tmp.size(), n);
    for (int j = 0; j < n && j < tmp.size(); j++)
      check({name, "_beat"}, tmp[j], 8'((exp >> (8 * (n - 1 - j))) & 64'hFF));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_checks  = 0;
    n_fail    = 0;
    reset     = 1'b1;
    in_data   = '0;
    in_cnt    = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    tick();
    check("reset_out_valid", out_valid_0, 1'b0);
    check("reset_out_data", out_data_0, 8'h00);
    check("reset_out_last", out_last_0, 1'b0);
    check("reset_out_idx", out_idx_0, 2'd0);
    check("reset_in_ready", in_ready_0, 1'b1);
    tick();
    reset = 1'b0;
    tick();

    // Full word, continuous out_ready.
    clear_logs();
    out_ready = 1'b1;
    send(32'h12345678, 2'd3);
    check("full_first_beat", out_data_0, 8'h12);
    drain();
    check_seq("full_msb", 0, 64'h12345678, 4);
    check_seq("full_lsb", 1, 64'h78563412, 4);
    check_seq("full_n3", 2, 64'h345678, 3);

    // Partial words.
    clear_logs();
    send(32'hAABBCCDD, 2'd1);
    drain();
    check_seq("part_msb", 0, 64'hAABB, 2);
    check_seq("part_lsb", 1, 64'hDDCC, 2);
    check_seq("part_n3", 2, 64'hBBCC, 2);
    check("part_idle_ready", in_ready_0, 1'b1);
    clear_logs();
    send(32'h5A6B7C8D, 2'd0);
    drain();
    check_seq("one_msb", 0, 64'h5A, 1);
    check_seq("one_lsb", 1, 64'h8D, 1);
    check_seq("one_n3", 2, 64'h6B, 1);

    // Count saturation on the three-chunk build.
    clear_logs();
    send(32'h00A1B2C3, 2'd3);
    drain();
    check_seq("sat_n3", 2, 64'hA1B2C3, 3);
    check_seq("sat_msb", 0, 64'h00A1B2C3, 4);

    // Backpressure while chunk 1 is presented.
    clear_logs();
    send(32'h12345678, 2'd3);
    tick();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("bp_hold_data", out_data_0, 8'h34);
      check("bp_hold_idx", out_idx_0, 2'd1);
      tick();
    end
    out_ready = 1'b1;
    drain();
    check_seq("bp_msb", 0, 64'h12345678, 4);
    check_seq("bp_lsb", 1, 64'h78563412, 4);

    // Back-to-back words with in_valid held.
    clear_logs();
    present(32'h01020304, 2'd3);
    present(32'h05060708, 2'd3);
    in_valid = 1'b0;
    drain();
    check_seq("b2b_msb", 0, 64'h0102030405060708, 8);
    check_seq("b2b_lsb", 1, 64'h0403020108070605, 8);
    check_seq("b2b_ready", 3, 64'h0408, 2);

    // Asynchronous reset after the first chunk.
    send(32'h12345678, 2'd3);
    tick();
    #2;
    reset = 1'b1;
    #1;
    check("async_out_valid", out_valid_0, 1'b0);
    check("async_out_data", out_data_0, 8'h00);
    check("async_in_ready", in_ready_0, 1'b1);
    tick();
    tick();
    reset = 1'b0;
    clear_logs();
    repeat (5) tick();
    check_seq("post_reset_msb", 0, 64'h0, 0);
    check("post_reset_ready", in_ready_0, 1'b1);
    clear_logs();
    send(32'hCAFEF00D, 2'd1);
    drain();
    check_seq("post_reset_word", 0, 64'hCAFE, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
